// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port, one outstanding transaction
module mem_port_arbiter #(
  parameter int NR_REQ   = 2,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  localparam int MASK_LEN = DATA_LEN / 8,
  localparam int GW       = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_LEN-1:0]   req_addr,
  input  logic [NR_REQ-1:0]            req_wen,
  input  logic [NR_REQ*DATA_LEN-1:0]   req_wdata,
  input  logic [NR_REQ*MASK_LEN-1:0]   req_wmask,
  output logic [NR_REQ-1:0]            resp_valid,
  output logic [DATA_LEN-1:0]          resp_rdata,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_LEN-1:0]          mem_addr,
  output logic                         mem_wen,
  output logic [DATA_LEN-1:0]          mem_wdata,
  output logic [MASK_LEN-1:0]          mem_wmask,
  input  logic                         mem_resp_valid,
  input  logic [DATA_LEN-1:0]          mem_rdata,
  output logic [GW-1:0]                grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state, next_state;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  sel;
  logic           found;
  logic           accept;
  logic           complete;

  // Scan from the highest offset down so the requester nearest ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NR_REQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    mem_valid  = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          req_ready  = NR_REQ'(1) << sel;
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          if (mem_resp_valid) begin
            complete   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        grant_id  <= sel;
        mem_addr  <= req_addr[int'(sel)*ADDR_LEN +: ADDR_LEN];
        mem_wen   <= req_wen[sel];
        mem_wdata <= req_wdata[int'(sel)*DATA_LEN +: DATA_LEN];
        mem_wmask <= req_wmask[int'(sel)*MASK_LEN +: MASK_LEN];
      end
      // The requester just served drops to lowest priority.
      if (complete) begin
        resp_valid <= NR_REQ'(1) << grant_id;
        resp_rdata <= mem_rdata;
        ptr        <= (grant_id == GW'(NR_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory port between NR_REQ requesters, for example instruction fetch and load/store.
- Sits between the CPU-side access units and the single memory/bus interface.
- Allows one outstanding transaction at a time and routes each response back to the requester that issued it.
- Request, address and data buses are flattened, packed vectors: requester n occupies slice n.

Parameters:
- NR_REQ, 2, number of requesters (2..8).
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width; must be a multiple of 8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NR_REQ  per-requester request valid.
- req_ready  out  NR_REQ  per-requester accept; one-hot or zero.
- req_addr  in  NR_REQ*ADDR_LEN  packed addresses.
- req_wen  in  NR_REQ  1 = write, 0 = read.
- req_wdata  in  NR_REQ*DATA_LEN  packed write data.
- req_wmask  in  NR_REQ*(DATA_LEN/8)  packed byte strobes.
- resp_valid  out  NR_REQ  one-cycle response pulse to the owning requester.
- resp_rdata  out  DATA_LEN  read data, broadcast to all requesters; meaningful only with resp_valid.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request.
- mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_LEN / 1 / DATA_LEN / DATA_LEN/8  latched request fields.
- mem_resp_valid  in  1  memory response (read data, or write done).
- mem_rdata  in  DATA_LEN  memory read data.
- grant_id  out  $clog2(NR_REQ) (min 1)  index of the current or last owner.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, ptr=0, grant_id=0.
  - mem_valid=0; mem_addr, mem_wen, mem_wdata and mem_wmask = 0.
  - resp_valid=0, resp_rdata=0.
  - req_ready is 0 while rst_n=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Select g = first n with req_valid[n]=1, scanning ptr, ptr+1, ... modulo NR_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch g's addr/wen/wdata/wmask into the mem_* registers, set grant_id=g, go to ISSUE.
  - No req_valid: stay in IDLE, all req_ready=0.
- ISSUE:
  - mem_valid=1 with the latched fields held stable; req_ready=0.
  - mem_ready=1 and mem_resp_valid=0: go to WAIT, mem_valid=0 next cycle.
  - mem_ready=1 and mem_resp_valid=1 in the same cycle: complete immediately (same actions as WAIT completion).
  - mem_ready=0: remain in ISSUE, fields unchanged.
- WAIT:
  - mem_resp_valid=1: register resp_rdata=mem_rdata, pulse resp_valid[grant_id]=1 for exactly the next cycle, ptr=(grant_id+1) mod NR_REQ, go to IDLE.
  - resp_rdata holds its value until the next completion.
- Latency:
  - Accept at cycle T; mem_valid high at T+1.
  - Minimum response (mem_ready and mem_resp_valid both at T+1): resp_valid at T+2.
  - A new accept is possible at T+2, the same cycle as resp_valid: back-to-back throughput of one transaction per 2 cycles.
- Fairness:
  - ptr advances only on completion, so the requester just served has lowest priority.
  - With all NR_REQ requesters continuously valid, grants rotate 0,1,...,NR_REQ-1,0.
- Requester rule:
  - Hold req_valid and payload until req_ready.
  - Deasserting req_valid before grant is legal; that request is simply never granted.
  - req_valid may be held high across a response to issue the next request.
- Stray inputs: mem_resp_valid in IDLE, or in ISSUE without mem_ready, is ignored, with no state change. mem_ready outside ISSUE is ignored.
- Reset mid-transaction: the transaction is abandoned with no resp_valid pulse; mem_valid is 0 from the cycle after the reset edge.
- Write responses: resp_valid pulses as for reads; resp_rdata is still loaded from mem_rdata and is don't-care for the requester.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, no req_valid for 5 cycles -> all outputs 0, ptr=0, mem_valid never high.
2. Single read:
   - Stimulus: req 1 valid, addr=0x8000_0010; mem_ready=1 at T+1, mem_resp_valid=1 with rdata=0xDEADBEEF at T+3.
   - Response: req_ready[1] at T; mem_addr=0x8000_0010 and mem_valid at T+1..T+1; resp_valid[1] at T+4 with resp_rdata=0xDEADBEEF; resp_valid[0]=0 throughout.
3. Round-robin contention:
   - Stimulus: NR_REQ=2, both valid continuously; memory with 1-cycle ready and same-cycle response.
   - Response: grant order 0,1,0,1; one accept every 2 cycles; each resp_valid lands on the matching requester.
4. Stall:
   - Stimulus: write from req 0, wdata=0x12345678, wmask=0xF; mem_ready low 3 cycles.
   - Response: mem_valid high 4 cycles with fields constant; req_ready stays 0 for req 1 meanwhile.
5. Spurious and simultaneous events: mem_resp_valid pulsed in IDLE -> no resp_valid. mem_ready and mem_resp_valid in the same ISSUE cycle -> resp_valid next cycle, WAIT skipped.
6. Reset mid-WAIT: rst_n low during WAIT, then mem_resp_valid arrives -> no resp_valid pulse, state IDLE, ptr=0.
